// File: rtl/serial_tx_if.sv
// Handshake and serial-line bundle between a word source and the serial transmitter.
// master = word source / line observer, slave = transmitter.
interface serial_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  load;
  logic                  ready;
  logic                  q;
  logic                  busy;
  logic                  done;

  modport master (
    output data,
    output load,
    input  ready,
    input  q,
    input  busy,
    input  done
  );

  modport slave (
    input  data,
    input  load,
    output ready,
    output q,
    output busy,
    output done
  );
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity, stop bit; registered line.
// Define SERIAL_TX_PARITY_EN to insert the even-parity bit between the data MSB and the stop bit.
module serial_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  serial_tx_if.slave bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                state;
  logic [CW-1:0]         cyc;
  logic [BW-1:0]         bitcnt;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic                  cyc_last;
  logic                  q_r;
  logic                  ready_r;
  logic                  busy_r;
  logic                  done_r;
`ifdef SERIAL_TX_PARITY_EN
  logic                  par;
`endif

  assign cyc_last  = (cyc == CYC_LAST);
  assign shift_nxt = shift >> 1;

  assign bus.q     = q_r;
  assign bus.ready = ready_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

  // Line value is loaded one edge ahead of each bit so q stays a pure flop output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cyc     <= '0;
      bitcnt  <= '0;
      shift   <= '0;
      q_r     <= 1'b1;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            state   <= START;
            shift   <= bus.data;
            cyc     <= '0;
            bitcnt  <= '0;
            q_r     <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par     <= ^bus.data;
`endif
          end
        end
        START: begin
          if (cyc_last) begin
            state <= DATA;
            cyc   <= '0;
            q_r   <= shift[0];
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        DATA: begin
          if (cyc_last) begin
            cyc <= '0;
            if (bitcnt == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
              state <= PARITY;
              q_r   <= par;
`else
              state <= STOP;
              q_r   <= 1'b1;
`endif
            end else begin
              bitcnt <= bitcnt + BW'(1);
              shift  <= shift_nxt;
              q_r    <= shift_nxt[0];
            end
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (cyc_last) begin
            state <= STOP;
            cyc   <= '0;
            q_r   <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cyc_last) begin
            state   <= IDLE;
            cyc     <= '0;
            q_r     <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          q_r     <= 1'b1;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

Serial frame transmitter: accepts a parallel word through a load/ready handshake and drives it onto a single registered serial line. Each frame is a start bit, the data LSB first, an optional parity bit, and a stop bit. This is the driving end of the single-bit data line that our capture flops and serial receivers sample, and it provides the stimulus source for those blocks in system benches.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (≥1)

- Clock  input  1  sole clock; all state changes on posedge
- Reset  input  1  synchronous, active-high reset
- Data  input  DATA_WIDTH  word to send; sampled only on acceptance
- Load  input  1  request to send Data
- Ready  output  1  high when a Load will be accepted
- Q  output  1  serial line, registered, idles high
- Busy  output  1  high while a frame is on the line
- Done  output  1  one-cycle pulse when the stop bit completes

## Operation
- Clock is the only clock. Reset is synchronous and active-high.
- Reset sampled high at an edge:
  - state ← IDLE; Q=1, Ready=1, Busy=0, Done=0
  - bit counter and cycle counter cleared
  - Reset dominates Load. Reset in mid-frame aborts the frame, and Q returns high at that edge.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: Q=1, Ready=1. If Load=1, go to START, copy Data into the shift register, and clear the counters.
  - START: Q=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: Q=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After DATA_WIDTH bits, go to PARITY if compiled in, otherwise STOP.
  - PARITY: Q=even parity (XOR of the accepted word) for CLKS_PER_BIT cycles, then STOP.
  - STOP: Q=1 for CLKS_PER_BIT cycles, then IDLE with Done=1 for exactly one cycle.
- Ready=1 exactly in IDLE. Busy is the complement of Ready outside reset.
- Load while Ready=0 is ignored. It is not queued and does not disturb the frame in flight.
- Data may change freely after acceptance; the frame uses the captured copy.
- Cycle counter width is clog2(CLKS_PER_BIT), minimum 1. Bit counter width is clog2(DATA_WIDTH+1). Counters never wrap within a frame.

## Timing
- N = DATA_WIDTH+2, or DATA_WIDTH+3 with parity. Frame length is N·CLKS_PER_BIT cycles.
- Load accepted at edge k:
  - Q=0, Ready=0, Busy=1 from edge k. Latency from accept to start bit is 1 edge.
  - Bit i (start = 0) occupies the cycles after edges k+i·CLKS_PER_BIT through k+(i+1)·CLKS_PER_BIT−1.
  - At edge k+N·CLKS_PER_BIT: state IDLE, Q=1, Ready=1, Busy=0, Done=1.
  - Done clears at the following edge.
- Load held high continuously: the next accept is at edge k+N·CLKS_PER_BIT+1. This gives exactly one idle-high cycle between frames, and the frame period is N·CLKS_PER_BIT+1.
- Load and Reset at the same edge: reset wins and nothing is accepted.
- Reset released with Load=1: the first accept is at the first edge where Reset=0.
- CLKS_PER_BIT=1: one bit per cycle, same rules.

## Configuration
- SERIAL_TX_PARITY_EN
  - Defined: the PARITY state exists, an even-parity bit follows the data MSB, and N=DATA_WIDTH+3.
  - Undefined: the PARITY state and XOR logic are absent, STOP follows DATA directly, and N=DATA_WIDTH+2.

## Test plan
- Reset, then idle 5 cycles → Q=1, Ready=1, Busy=0, Done=0 throughout.
- Defaults, no parity; Load=1 with Data=0xA5 for one cycle at edge k:
  - Q reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - Done pulses once at edge k+40; Ready returns at k+40.
- Load held high with Data=0x3C then 0xFF → second start bit at edge k+41, one idle-high cycle between frames.
- Mid-frame Load=1 with Data=0x00 while Busy=1 → ignored; the in-flight frame is bit-exact and no extra frame follows.
- Reset asserted 15 cycles into a frame → Q=1, Ready=1, Busy=0 at that edge; no Done pulse.
- SERIAL_TX_PARITY_EN defined; Data=0xA5 → parity bit 0 after the MSB and Done at k+44. Data=0x07 → parity bit 1.
